// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, num_masters masters onto one
// slave port. The bus stays with one master for its whole cyc; priority
// rotates from the last owner. Slave responses go back combinationally to the
// granted master only.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   defined   : stall counter aborts a transfer after TIMEOUT stalled cycles
//               with a one-cycle err to the owner, then masks cyc/stb until
//               the owner drops cyc.
//   undefined : no supervision; a stalled slave holds the bus indefinitely.
//
// state | meaning
// IDLE  | no owner; arbitration picks the first requester after last
// GRANT | bus owned by master grant until it drops cyc

module wb_rr_arbiter #(
  parameter int num_masters = 2,
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [num_masters*aw-1:0]     wbm_adr_i,
  input  logic [num_masters*dw-1:0]     wbm_dat_i,
  input  logic [num_masters*(dw/8)-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]        wbm_we_i,
  input  logic [num_masters-1:0]        wbm_cyc_i,
  input  logic [num_masters-1:0]        wbm_stb_i,
  input  logic [num_masters*3-1:0]      wbm_cti_i,
  input  logic [num_masters*2-1:0]      wbm_bte_i,
  output logic [dw-1:0]                 wbm_dat_o,
  output logic [num_masters-1:0]        wbm_ack_o,
  output logic [num_masters-1:0]        wbm_err_o,
  output logic [num_masters-1:0]        wbm_rty_o,
  output logic [aw-1:0]                 wbs_adr_o,
  output logic [dw-1:0]                 wbs_dat_o,
  output logic [dw/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [dw-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i
);

  localparam int gw = (num_masters > 1) ? $clog2(num_masters) : 1;
  localparam int sw = dw / 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [gw-1:0]   grant_q, grant_d;
  logic [gw-1:0]   last_q, last_d;
  logic [gw-1:0]   winner;
  logic            any_req;
  logic            active;
  logic            cur_cyc;
  logic            cur_stb;
  logic            bus_mask;
  logic            to_err;

  assign active = (state_q == GRANT);

  // Round-robin search starting one past the last owner.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = 1; k <= num_masters; k++) begin
      idx = (int'(last_q) + k) % num_masters;
      if (!any_req && wbm_cyc_i[idx]) begin
        winner  = gw'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Request-side mux from the current grant index.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    cur_cyc   = 1'b0;
    cur_stb   = 1'b0;
    for (int i = 0; i < num_masters; i++) begin
      if (grant_q == gw'(i)) begin
        wbs_adr_o = wbm_adr_i[i*aw +: aw];
        wbs_dat_o = wbm_dat_i[i*dw +: dw];
        wbs_sel_o = wbm_sel_i[i*sw +: sw];
        wbs_we_o  = wbm_we_i[i];
        wbs_cti_o = wbm_cti_i[i*3 +: 3];
        wbs_bte_o = wbm_bte_i[i*2 +: 2];
        cur_cyc   = wbm_cyc_i[i];
        cur_stb   = wbm_stb_i[i];
      end
    end
  end

  // Next-state: take a new owner from idle, or hand over as soon as the
  // owner's cyc is seen low (the low cycle itself is the gap between owners).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          grant_d = winner;
          last_d  = winner;
        end
      end
      GRANT: begin
        if (!cur_cyc) begin
          if (any_req) begin
            grant_d = winner;
            last_d  = winner;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; after reset master 0 has first priority.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= gw'(num_masters - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int cw = $clog2(TIMEOUT + 1);

  logic [cw-1:0] stall_cnt;
  logic          abort_q;
  logic          to_hit;
  logic          any_resp;

  assign any_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign to_hit   = active && cur_cyc && !abort_q && (stall_cnt == cw'(TIMEOUT));
  assign to_err   = to_hit;
  assign bus_mask = abort_q | to_hit;

  // Stall counter and abort latch; both restart whenever ownership ends.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stall_cnt <= '0;
      abort_q   <= 1'b0;
    end else if (!active || !cur_cyc) begin
      stall_cnt <= '0;
      abort_q   <= 1'b0;
    end else begin
      if (to_hit) begin
        abort_q <= 1'b1;
      end
      if (!cur_stb || any_resp || abort_q || to_hit) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  // No stall supervision; the mask only reflects an illegal TIMEOUT below 1.
  assign bus_mask = (TIMEOUT < 1);
  assign to_err   = 1'b0;
`endif

  assign wbs_cyc_o = active & cur_cyc & ~bus_mask;
  assign wbs_stb_o = wbs_cyc_o & cur_stb;
  assign wbm_dat_o = wbs_dat_i;

  // Responses reach the granted master only.
  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    for (int i = 0; i < num_masters; i++) begin
      if (active && (grant_q == gw'(i))) begin
        wbm_ack_o[i] = wbs_ack_i;
        wbm_err_o[i] = wbs_err_i | to_err;
        wbm_rty_o[i] = wbs_rty_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with three masters and TIMEOUT=8.
// Inputs change on the falling edge; outputs are checked #1 later.
module tb_wb_rr_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [NM*AW-1:0]  wbm_adr_i;
  logic [NM*DW-1:0]  wbm_dat_i;
  logic [NM*4-1:0]   wbm_sel_i;
  logic [NM-1:0]     wbm_we_i;
  logic [NM-1:0]     wbm_cyc_i;
  logic [NM-1:0]     wbm_stb_i;
  logic [NM*3-1:0]   wbm_cti_i;
  logic [NM*2-1:0]   wbm_bte_i;
  logic [DW-1:0]     wbm_dat_o;
  logic [NM-1:0]     wbm_ack_o;
  logic [NM-1:0]     wbm_err_o;
  logic [NM-1:0]     wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic              wbs_we_o;
  logic              wbs_cyc_o;
  logic              wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [DW-1:0]     wbs_dat_i;
  logic              wbs_ack_i;
  logic              wbs_err_i;
  logic              wbs_rty_i;

  int checks = 0;
  int failures = 0;

  wb_rr_arbiter #(.num_masters(NM), .aw(AW), .dw(DW), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_m(input int i, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [2:0] cti);
    wbm_cyc_i[i]        = cyc;
    wbm_stb_i[i]        = cyc;
    wbm_we_i[i]         = we;
    wbm_adr_i[i*AW +: AW] = adr;
    wbm_dat_i[i*DW +: DW] = dat;
    wbm_sel_i[i*4 +: 4]   = sel;
    wbm_cti_i[i*3 +: 3]   = cti;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int errs;
    rst = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = '0;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    step();
    step();
    #1;
    check("rst_cyc", 32'(wbs_cyc_o), 32'd0);
    check("rst_stb", 32'(wbs_stb_o), 32'd0);
    check("rst_ack", 32'(wbm_ack_o), 32'd0);

    // Two masters request together right after reset release.
    rst = 1'b0;
    step();
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 3'b000);
    #1 check("t1_latency_cyc", 32'(wbs_cyc_o), 32'd0);
    step();
    wbs_ack_i = 1'b1;
    wbs_dat_i = 32'hDEAD0010;
    #1;
    check("t1_m0_cyc", 32'(wbs_cyc_o), 32'd1);
    check("t1_m0_adr", wbs_adr_o, 32'h10);
    check("t1_m0_ack", 32'(wbm_ack_o), 32'b001);
    check("t1_m0_dat", wbm_dat_o, 32'hDEAD0010);
    step();
    wbs_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
    #1 check("t1_gap_cyc", 32'(wbs_cyc_o), 32'd0);
    step();
    wbs_ack_i = 1'b1;
    wbs_dat_i = 32'hDEAD0020;
    #1;
    check("t1_m1_cyc", 32'(wbs_cyc_o), 32'd1);
    check("t1_m1_adr", wbs_adr_o, 32'h20);
    check("t1_m1_ack", 32'(wbm_ack_o), 32'b010);
    step();
    wbs_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 3'b000);
    #1 check("t1_release", 32'(wbs_cyc_o), 32'd0);

    // Three masters keep requesting single-beat writes; order 0,1,2,0,1,2.
    do_reset();
    for (int i = 0; i < NM; i++)
      set_m(i, 1'b1, 1'b1, 32'h100 * i, 32'hA0 + i, 4'b0001 << i, 3'b000);
    step();
    for (int b = 0; b < 6; b++) begin
      int o;
      o = b % 3;
      wbs_ack_i = 1'b1;
      #1;
      check($sformatf("t2_cyc_%0d", b), 32'(wbs_cyc_o), 32'd1);
      check($sformatf("t2_dat_%0d", b), wbs_dat_o, 32'hA0 + o);
      check($sformatf("t2_sel_%0d", b), 32'(wbs_sel_o), 32'(4'b0001 << o));
      check($sformatf("t2_we_%0d", b), 32'(wbs_we_o), 32'd1);
      check($sformatf("t2_ack_%0d", b), 32'(wbm_ack_o), 32'(3'b001 << o));
      step();
      wbs_ack_i = 1'b0;
      wbm_cyc_i[o] = 1'b0;
      wbm_stb_i[o] = 1'b0;
      #1 check($sformatf("t2_gap_%0d", b), 32'(wbs_cyc_o), 32'd0);
      step();
      wbm_cyc_i[o] = 1'b1;
      wbm_stb_i[o] = 1'b1;
    end
    wbm_cyc_i = '0;
    wbm_stb_i = '0;

    // Master 1 burst while master 0 waits; then rty/err routing to master 0.
    do_reset();
    set_m(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 3'b010);
    step();
    set_m(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 3'b000);
    for (int k = 0; k < 4; k++) begin
      set_m(1, 1'b1, 1'b0, 32'h40 + 4 * k, 32'h0, 4'hF, (k == 3) ? 3'b111 : 3'b010);
      wbs_ack_i = 1'b1;
      #1;
      check($sformatf("t3_adr_%0d", k), wbs_adr_o, 32'h40 + 4 * k);
      check($sformatf("t3_cti_%0d", k), 32'(wbs_cti_o), (k == 3) ? 32'd7 : 32'd2);
      check($sformatf("t3_ack_%0d", k), 32'(wbm_ack_o), 32'b010);
      step();
    end
    wbs_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 3'b000);
    #1 check("t3_gap", 32'(wbs_cyc_o), 32'd0);
    step();
    set_m(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF, 3'b010);
    wbs_rty_i = 1'b1;
    #1;
    check("t3_m0_adr", wbs_adr_o, 32'h80);
    check("t3_m0_cyc", 32'(wbs_cyc_o), 32'd1);
    check("t4_rty", 32'(wbm_rty_o), 32'b001);
    check("t4_rty_err", 32'(wbm_err_o), 32'b000);
    check("t4_rty_ack", 32'(wbm_ack_o), 32'b000);
    step();
    wbs_rty_i = 1'b0;
    wbs_err_i = 1'b1;
    #1;
    check("t4_err", 32'(wbm_err_o), 32'b001);
    check("t4_err_rty", 32'(wbm_rty_o), 32'b000);
    step();
    wbs_err_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h80, 32'h0, 4'hF, 3'b000);
    step();
    #1 check("t5_m1_owner", wbs_adr_o, 32'h44);

    // Reset while master 1 is mid-burst and both masters still request.
    set_m(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 3'b000);
    wbs_ack_i = 1'b1;
    rst = 1'b1;
    step();
    #1;
    check("t5_rst_cyc", 32'(wbs_cyc_o), 32'd0);
    check("t5_rst_stb", 32'(wbs_stb_o), 32'd0);
    check("t5_rst_ack", 32'(wbm_ack_o), 32'd0);
    step();
    rst = 1'b0;
    wbs_ack_i = 1'b0;
    #1 check("t5_idle_cyc", 32'(wbs_cyc_o), 32'd0);
    step();
    #1;
    check("t5_m0_first", wbs_adr_o, 32'h80);
    check("t5_m0_cyc", 32'(wbs_cyc_o), 32'd1);
    wbm_cyc_i = '0;
    wbm_stb_i = '0;
    step();

    // Slave never answers master 2.
    do_reset();
    set_m(2, 1'b1, 1'b0, 32'hC0, 32'h0, 4'hF, 3'b000);
    step();
    #1 check("t6_stb_rise", 32'(wbs_stb_o), 32'd1);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t6_noerr_%0d", k), 32'(wbm_err_o), 32'd0);
      step();
      #1;
    end
    check("t6_err_pulse", 32'(wbm_err_o), 32'b100);
    check("t6_cyc_drop", 32'(wbs_cyc_o), 32'd0);
    step();
    #1;
    check("t6_err_once", 32'(wbm_err_o), 32'd0);
    check("t6_masked", 32'(wbs_cyc_o), 32'd0);
`else
    errs = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      #1;
      if (wbm_err_o != '0) errs++;
    end
    check("t6_no_err", 32'(errs), 32'd0);
    check("t6_still_cyc", 32'(wbs_cyc_o), 32'd1);
`endif
    wbm_cyc_i = '0;
    wbm_stb_i = '0;
    step();
    #1 check("t6_release", 32'(wbs_cyc_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Wishbone round-robin arbiter connecting `num_masters` Wishbone masters to a single slave port; it is the many-to-one counterpart of the address-decoding one-to-many mux in the interconnect. It locks the bus to one master for the full duration of its `cyc` and rotates priority fairly between cycles. It sits between the masters and `wb_mux` input, or directly in front of a shared slave.

## Interface
- `num_masters`, 2, number of master ports (1..16)
- `aw`, 32, address width
- `dw`, 32, data width (sel width = dw/8)
- `TIMEOUT`, 255, stall cycles before timeout abort (only with `WB_ARB_TIMEOUT_EN`), ≥1

Ports:
- `wb_clk_i` in 1: clock
- `wb_rst_i` in 1: synchronous reset, active-high
- `wbm_adr_i` in num_masters*aw: master addresses, master i at [i*aw+:aw]
- `wbm_dat_i` in num_masters*dw: master write data
- `wbm_sel_i` in num_masters*dw/8: byte selects
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i` in num_masters: per-master controls
- `wbm_cti_i` in num_masters*3, `wbm_bte_i` in num_masters*2: burst info
- `wbm_dat_o` out dw: slave read data, broadcast to all masters
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o` out num_masters: responses, granted master only
- `wbs_adr_o` out aw, `wbs_dat_o` out dw, `wbs_sel_o` out dw/8, `wbs_we_o`, `wbs_cyc_o`, `wbs_stb_o` out 1, `wbs_cti_o` out 3, `wbs_bte_o` out 2: slave side
- `wbs_dat_i` in dw, `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i` in 1: slave responses

## Operation
- State: `active` (1 bit), `grant` (index register, $clog2(num_masters) bits, min 1), `last` (last granted index).
- IDLE (`active`=0): if any `wbm_cyc_i` high, pick the first requester searching `last+1, last+2, …` modulo `num_masters`; next cycle `grant`←winner, `last`←winner, `active`←1.
- GRANT (`active`=1): hold `grant` while `wbm_cyc_i[grant]`=1. When it samples low, `active`←0 and, in the same cycle, arbitration as in IDLE runs, so a waiting master is granted next cycle.
- Slave outputs: adr/dat/sel/we/cti/bte always muxed from `grant`; `wbs_cyc_o` = `active` & `wbm_cyc_i[grant]`; `wbs_stb_o` = `wbs_cyc_o` & `wbm_stb_i[grant]`.
- Master responses: `wbm_ack_o[i]` = `wbs_ack_i` & `active` & (i==`grant`); same for err/rty. Non-granted masters see 0 and stall.
- Requests from a master that drops `cyc` before being granted are forgotten.
- Reset: `active`=0, `grant`=0, `last`=num_masters-1 (master 0 has first priority). All `wbm_*_o` responses 0 and `wbs_cyc_o`/`wbs_stb_o` 0 during and after reset. Reset mid-transfer aborts immediately; the slave sees `cyc` drop on the next edge.
- `num_masters`=1: `grant` constant 0, still one cycle of grant latency.

## Timing
- Grant latency: `cyc` first high at cycle N (bus idle) → `wbs_cyc_o` high at N+1.
- Handover: granted master drops `cyc` at M → `wbs_cyc_o` low at M (combinational), next master's `wbs_cyc_o` high at M+1. There is a guaranteed ≥1 cycle `cyc` gap between owners.
- Response path (ack/err/rty/dat) is combinational slave→master, zero added latency. Request path adds no registers after grant.
- Simultaneous requests: rotation order strictly from `last+1`.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined: a stall counter clears when `wbs_stb_o`=0 or when any slave response arrives, and increments otherwise. When it reaches `TIMEOUT`, the granted master receives a one-cycle `wbm_err_o` pulse; `wbs_cyc_o`/`wbs_stb_o` are then masked low until that master drops `cyc`, after which normal release occurs. The counter is cleared on reset and on grant change.
- Undefined: no counter and no timeout error; a stalled slave blocks the bus indefinitely.

## Test plan
- Reset release with master 0 and 1 both raising `cyc`/`stb` at cycle N, reading adr 0x10/0x20 → master 0 granted at N+1, `wbs_adr_o`=0x10, ack only on `wbm_ack_o[0]`; master 1 granted after master 0 drops `cyc`, with a 1-cycle `wbs_cyc_o` gap.
- Three masters continuously requesting, single-beat writes of 0xA0+i → grant order 0,1,2,0,1,2; each slave write carries the owner's data and sel.
- Master 1 does a 4-beat incrementing burst (cti=010→111) while master 0 requests → grant is not released mid-burst; master 0 is granted the cycle after master 1's `cyc` falls.
- Slave returns `rty`, then `err` → routed only to the granted master's `wbm_rty_o`/`wbm_err_o`; other masters' outputs stay 0.
- Reset asserted mid-burst → next cycle `wbs_cyc_o`=0 and all responses 0; after release, master 0 wins first.
- With `WB_ARB_TIMEOUT_EN`, `TIMEOUT`=8, slave never acks → `wbm_err_o[grant]` pulses exactly 8 cycles after `wbs_stb_o` rises and `wbs_cyc_o` drops; without the macro there is no err after 100 cycles.
